stereo_gain_sequencer: RTL and testbench

- Sits between the stereo mode controller's 2-bit `aural_state` output and the codec sample path.
- Converts `aural_state` into per-channel gain targets and ramps the left/right gains toward those targets, one step per accepted sample, so mode changes do not click.
- Scales each incoming mono sample into left/right samples using one shared multiplier, time-multiplexed over two cycles and sequenced by a small FSM.

---
 rtl/stereo_gain_sequencer.sv | 150 +++++++++++++++
 tb/tb_stereo_gain_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/stereo_gain_sequencer.sv
// Stereo gain sequencer: maps aural_state to L/R gain targets, ramps gains per sample, scales mono input to L/R.
// Latency: new_sample in cycle k -> sample_out_valid in cycle k+3; one shared multiplier used over two cycles.
// Backpressure: none; new_sample outside IDLE is dropped and sets the sticky overrun flag.
module stereo_gain_sequencer #(
   parameter int SAMPLE_W = 16,
   parameter int GAIN_W   = 8,
   parameter int STEP     = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [1:0]                 aural_state,
   input  logic                       new_sample,
   input  logic signed [SAMPLE_W-1:0] sample_in,
   output logic signed [SAMPLE_W-1:0] sample_left,
   output logic signed [SAMPLE_W-1:0] sample_right,
   output logic                       sample_out_valid,
   output logic                       ramping,
   output logic                       overrun
);

   localparam int PROD_W = SAMPLE_W + GAIN_W + 2;
   localparam logic [GAIN_W:0]   UNITY  = {1'b1, {GAIN_W{1'b0}}};
   localparam logic [GAIN_W+1:0] STEP_V = (GAIN_W+2)'(STEP);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUL_L = 2'd1,
      MUL_R = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t                     state_q, state_d;
   logic signed [SAMPLE_W-1:0] sample_q, sample_d;
   logic [GAIN_W:0]            gain_l_q, gain_l_d, gain_r_q, gain_r_d;
   logic [GAIN_W:0]            tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
   logic signed [SAMPLE_W-1:0] left_q, left_d, right_q, right_d;
   logic                       valid_q, valid_d;
   logic                       overrun_q, overrun_d;

   logic [GAIN_W:0]            map_l, map_r;
   logic [GAIN_W:0]            mul_gain;
   logic signed [PROD_W-1:0]   product;
   logic signed [SAMPLE_W-1:0] scaled;

   // Move a gain one STEP toward its target without overshooting; the
   // extra top bit keeps g+STEP from wrapping when g is at unity.
   function automatic logic [GAIN_W:0] step_gain(input logic [GAIN_W:0] g,
                                                  input logic [GAIN_W:0] t);
      logic [GAIN_W+1:0] up;
      logic [GAIN_W+1:0] down_gap;
      up       = {1'b0, g} + STEP_V;
      down_gap = {1'b0, g} - {1'b0, t};
      step_gain = g;
      if (g < t) begin
         if (up >= {1'b0, t}) step_gain = t;
         else                 step_gain = up[GAIN_W:0];
      end else if (g > t) begin
         if (down_gap <= STEP_V) step_gain = t;
         else                    step_gain = g - STEP_V[GAIN_W:0];
      end
   endfunction

   assign map_l = aural_state[1] ? UNITY : '0;
   assign map_r = aural_state[0] ? UNITY : '0;

   // Shared multiplier: gain operand chosen by which channel is being computed.
   always_comb begin
      mul_gain = (state_q == MUL_R) ? gain_r_q : gain_l_q;
   end

   // Gain is non-negative, so it is zero-extended into a signed operand;
   // taking bits above GAIN_W is an arithmetic shift (floor) plus truncation.
   assign product = PROD_W'(sample_q) * PROD_W'($signed({1'b0, mul_gain}));
   assign scaled  = product[GAIN_W +: SAMPLE_W];

   // Next-state and datapath updates sequenced by the FSM.
   always_comb begin
      state_d   = state_q;
      sample_d  = sample_q;
      gain_l_d  = gain_l_q;
      gain_r_d  = gain_r_q;
      tgt_l_d   = tgt_l_q;
      tgt_r_d   = tgt_r_q;
      left_d    = left_q;
      right_d   = right_q;
      valid_d   = 1'b0;
      overrun_d = overrun_q | (new_sample && (state_q != IDLE));
      case (state_q)
         IDLE: begin
            if (new_sample) begin
               state_d  = MUL_L;
               sample_d = sample_in;
               tgt_l_d  = map_l;
               tgt_r_d  = map_r;
               gain_l_d = step_gain(gain_l_q, map_l);
               gain_r_d = step_gain(gain_r_q, map_r);
            end
         end
         MUL_L: begin
            left_d  = scaled;
            state_d = MUL_R;
         end
         MUL_R: begin
            right_d = scaled;
            valid_d = 1'b1;
            state_d = OUT;
         end
         OUT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset restores unity gains and quiet outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         sample_q  <= '0;
         gain_l_q  <= UNITY;
         gain_r_q  <= UNITY;
         tgt_l_q   <= UNITY;
         tgt_r_q   <= UNITY;
         left_q    <= '0;
         right_q   <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sample_q  <= sample_d;
         gain_l_q  <= gain_l_d;
         gain_r_q  <= gain_r_d;
         tgt_l_q   <= tgt_l_d;
         tgt_r_q   <= tgt_r_d;
         left_q    <= left_d;
         right_q   <= right_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign sample_left      = left_q;
   assign sample_right     = right_q;
   assign sample_out_valid = valid_q;
   assign overrun          = overrun_q;
   assign ramping          = (gain_l_q != tgt_l_q) || (gain_r_q != tgt_r_q);

endmodule

// File: tb/tb_stereo_gain_sequencer.sv
// Bench for stereo_gain_sequencer: directed scenarios plus random samples against a gain/target model.
// Latency: expects sample_out_valid exactly 3 cycles after each accepted new_sample.
// Backpressure: exercises dropped samples (overrun) and reset in flight.
module tb_stereo_gain_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  aural_state = 2'b11;
   logic        new_sample = 1'b0;
   logic [15:0] sample_in = '0;
   logic [15:0] sample_left, sample_right;
   logic        sample_out_valid, ramping, overrun;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: gains and targets as plain integers (256 = unity).
   int gl = 256, gr = 256, tl = 256, tr = 256;
   logic [15:0] exp_l, exp_r;

   stereo_gain_sequencer #(.SAMPLE_W(16), .GAIN_W(8), .STEP(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .aural_state      (aural_state),
      .new_sample       (new_sample),
      .sample_in        (sample_in),
      .sample_left      (sample_left),
      .sample_right     (sample_right),
      .sample_out_valid (sample_out_valid),
      .ramping          (ramping),
      .overrun          (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int approach(input int g, input int t);
      if (g < t) return (g + 8 > t) ? t : g + 8;
      if (g > t) return (g - 8 < t) ? t : g - 8;
      return g;
   endfunction

   // Signed sample times gain over 256, rounded toward minus infinity.
   function automatic logic [15:0] scale(input logic [15:0] s, input int g);
      int p;
      p = $signed(s) * g;
      return 16'(p >>> 8);
   endfunction

   task automatic model_accept(input logic [1:0] st, input logic [15:0] s);
      tl = st[1] ? 256 : 0;
      tr = st[0] ? 256 : 0;
      gl = approach(gl, tl);
      gr = approach(gr, tr);
      exp_l = scale(s, gl);
      exp_r = scale(s, gr);
   endtask

   task automatic model_reset();
      gl = 256; gr = 256; tl = 256; tr = 256;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // Present one sample; returns at the negedge of the cycle after acceptance.
   task automatic accept(input logic [1:0] st, input logic [15:0] s);
      @(negedge clk);
      aural_state = st;
      sample_in   = s;
      new_sample  = 1'b1;
      model_accept(st, s);
      @(negedge clk);
      new_sample = 1'b0;
   endtask

   // Called one cycle after acceptance; waits (bounded) for the valid pulse.
   task automatic expect_out(input string tag, input int start_n);
      int n;
      n = start_n;
      while (!sample_out_valid && n < 8) begin
         @(negedge clk);
         n++;
      end
      check({tag, ".latency"}, n, 3);
      check({tag, ".left"}, {16'h0, sample_left}, {16'h0, exp_l});
      check({tag, ".right"}, {16'h0, sample_right}, {16'h0, exp_r});
      check({tag, ".ramping"}, {31'h0, ramping}, {31'h0, (gl != tl) || (gr != tr)});
      @(negedge clk);
      check({tag, ".pulse_width"}, {31'h0, sample_out_valid}, 32'h0);
      check({tag, ".left_hold"}, {16'h0, sample_left}, {16'h0, exp_l});
   endtask

   task automatic do_sample(input logic [1:0] st, input logic [15:0] s, input string tag);
      accept(st, s);
      expect_out(tag, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      int n;

      // 1: reset state, then full-gain passthrough.
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      check("rst.left", {16'h0, sample_left}, 32'h0);
      check("rst.right", {16'h0, sample_right}, 32'h0);
      check("rst.valid", {31'h0, sample_out_valid}, 32'h0);
      check("rst.overrun", {31'h0, overrun}, 32'h0);
      check("rst.ramping", {31'h0, ramping}, 32'h0);
      do_sample(2'b11, 16'h4000, "s1");
      check("s1.left_const", {16'h0, sample_left}, 32'h4000);

      // 2: left-only, right ramps down over 32 samples.
      for (int i = 1; i <= 34; i++) begin
         do_sample(2'b10, 16'h4000, "s2");
         if (i == 1) begin
            check("s2.first_left", {16'h0, sample_left}, 32'h4000);
            check("s2.first_right", {16'h0, sample_right}, 32'h3E00);
            check("s2.first_ramping", {31'h0, ramping}, 32'h1);
         end
         if (i == 32) check("s2.last_ramping", {31'h0, ramping}, 32'h0);
         if (i >= 32) check("s2.right_zero", {16'h0, sample_right}, 32'h0);
      end

      // 3: swap to right-only; gains cross at 128.
      for (int i = 1; i <= 32; i++) begin
         do_sample(2'b01, 16'h4000, "s3");
         if (i == 16) begin
            check("s3.mid_left", {16'h0, sample_left}, 32'h2000);
            check("s3.mid_right", {16'h0, sample_right}, 32'h2000);
         end
         if (i == 32) begin
            check("s3.end_left", {16'h0, sample_left}, 32'h0);
            check("s3.end_right", {16'h0, sample_right}, 32'h4000);
         end
      end

      // 4: negative rounding at gain 128 on both channels.
      for (int i = 1; i <= 15; i++) do_sample(2'b10, 16'h4000, "s4.ramp");
      do_sample(2'b10, 16'h8000, "s4.neg");
      check("s4.neg_left", {16'h0, sample_left}, 32'hC000);
      check("s4.neg_right", {16'h0, sample_right}, 32'hC000);
      do_sample(2'b01, 16'h1234, "s4.back");
      do_sample(2'b10, 16'hFFFF, "s4.m1");
      check("s4.m1_left", {16'h0, sample_left}, 32'hFFFF);
      check("s4.m1_right", {16'h0, sample_right}, 32'hFFFF);

      // Random modes and samples against the model.
      for (int i = 0; i < 40; i++) begin
         do_sample(2'($urandom_range(0, 3)), 16'($urandom), "rand");
      end

      // 5: overrun from back-to-back strobes.
      do_reset();
      check("s5.rst_left", {16'h0, sample_left}, 32'h0);
      @(negedge clk);
      aural_state = 2'b11;
      sample_in   = 16'h1111;
      new_sample  = 1'b1;
      model_accept(2'b11, 16'h1111);
      @(negedge clk);
      sample_in = 16'h7777;
      @(negedge clk);
      new_sample = 1'b0;
      expect_out("s5", 2);
      check("s5.overrun", {31'h0, overrun}, 32'h1);
      pulses = 0;
      repeat (6) begin
         @(negedge clk);
         if (sample_out_valid) pulses++;
      end
      check("s5.extra_pulses", pulses, 0);
      do_sample(2'b11, 16'h2222, "s5.next");
      check("s5.overrun_sticky", {31'h0, overrun}, 32'h1);
      do_reset();
      check("s5.overrun_clr", {31'h0, overrun}, 32'h0);

      // 6a: reset during MUL_R.
      for (int i = 0; i < 3; i++) do_sample(2'b00, 16'h4000, "s6a.pre");
      accept(2'b00, 16'h4000);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("s6a.left", {16'h0, sample_left}, 32'h0);
      check("s6a.right", {16'h0, sample_right}, 32'h0);
      check("s6a.valid", {31'h0, sample_out_valid}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      pulses = 0;
      n = 0;
      repeat (6) begin
         @(negedge clk);
         if (sample_out_valid) pulses++;
         n++;
      end
      check("s6a.no_pulse", pulses, 0);
      do_sample(2'b11, 16'h4000, "s6a.post");
      check("s6a.post_left", {16'h0, sample_left}, 32'h4000);

      // 6b: mode change during MUL_L does not affect the sample in flight.
      accept(2'b11, 16'h5555);
      aural_state = 2'b00;
      expect_out("s6b", 1);
      check("s6b.full_left", {16'h0, sample_left}, 32'h5555);
      do_sample(2'b00, 16'h4000, "s6b.next");
      check("s6b.next_left", {16'h0, sample_left}, 32'h3E00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
